// File: rtl/coord_gen_pkg.sv
// Shared widths, filter margin and FSM state type for the block coordinate generator.
package coord_gen_pkg;
    localparam int COORD_W = 8;
    localparam int MARGIN  = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH
    } state_t;
endpackage

// File: rtl/coord_axis_cnt.sv
// One axis of the block-origin walk: steps by step_size and wraps to 0 after reaching limit.
module coord_axis_cnt
    import coord_gen_pkg::*;
(
    input  logic               CLK,
    input  logic               RST_SYNC,
    input  logic               clear,
    input  logic               step,
    input  logic [COORD_W-1:0] step_size,
    input  logic [COORD_W-1:0] limit,
    output logic [COORD_W-1:0] origin_nxt,
    output logic               at_last
);
    logic [COORD_W-1:0] origin;

    assign at_last = (origin == limit);

    // origin_nxt is the value being loaded, so the caller can register it in the same edge
    always_comb begin
        origin_nxt = origin;
        if (clear)
            origin_nxt = '0;
        else if (step)
            origin_nxt = at_last ? '0 : origin + step_size;
    end

    always_ff @(posedge CLK) begin
        if (RST_SYNC)
            origin <= '0;
        else
            origin <= origin_nxt;
    end
endmodule

// File: rtl/block_coord_gen.sv
// Raster-order block-origin generator with WRITE_EN/READY_IN handshake per block.
// Define BLOCK_COORD_GEN_MARGIN_EN to shift emitted coordinates by -MARGIN for the filter border.
module block_coord_gen
    import coord_gen_pkg::*;
#(
    parameter int BLOCK_W = 8,
    parameter int BLOCK_H = 8,
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64
) (
    input  logic                      CLK,
    input  logic                      RST_SYNC,
    input  logic                      START,
    input  logic                      READY_IN,
    output logic signed [COORD_W-1:0] COORD_X,
    output logic signed [COORD_W-1:0] COORD_Y,
    output logic                      WRITE_EN,
    output logic                      BUSY,
    output logic                      DONE
);
    localparam logic [COORD_W-1:0] X_STEP = COORD_W'(BLOCK_W);
    localparam logic [COORD_W-1:0] Y_STEP = COORD_W'(BLOCK_H);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(FRAME_W - BLOCK_W);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(FRAME_H - BLOCK_H);
`ifdef BLOCK_COORD_GEN_MARGIN_EN
    localparam logic [COORD_W-1:0] OFFSET = COORD_W'(MARGIN);
`else
    localparam logic [COORD_W-1:0] OFFSET = '0;
`endif

    state_t             state;
    logic               scan_start;
    logic               last_blk;
    logic               advance;
    logic               x_at_last;
    logic               y_at_last;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;

    assign scan_start = (state == IDLE) && START;
    assign last_blk   = x_at_last && y_at_last;
    assign advance    = (state == WAIT) && READY_IN && !last_blk;

    coord_axis_cnt u_x_cnt (
        .CLK        (CLK),
        .RST_SYNC   (RST_SYNC),
        .clear      (scan_start),
        .step       (advance),
        .step_size  (X_STEP),
        .limit      (X_LAST),
        .origin_nxt (x_nxt),
        .at_last    (x_at_last)
    );

    // Y advances only when X wraps back to column 0
    coord_axis_cnt u_y_cnt (
        .CLK        (CLK),
        .RST_SYNC   (RST_SYNC),
        .clear      (scan_start),
        .step       (advance && x_at_last),
        .step_size  (Y_STEP),
        .limit      (Y_LAST),
        .origin_nxt (y_nxt),
        .at_last    (y_at_last)
    );

    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            state    <= IDLE;
            COORD_X  <= '0;
            COORD_Y  <= '0;
            WRITE_EN <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        state    <= ISSUE;
                        COORD_X  <= $signed(x_nxt - OFFSET);
                        COORD_Y  <= $signed(y_nxt - OFFSET);
                        WRITE_EN <= 1'b1;
                        BUSY     <= 1'b1;
                    end
                end
                ISSUE: begin
                    WRITE_EN <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (READY_IN) begin
                        if (last_blk) begin
                            state <= FINISH;
                            DONE  <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            COORD_X  <= $signed(x_nxt - OFFSET);
                            COORD_Y  <= $signed(y_nxt - OFFSET);
                            WRITE_EN <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/block_coord_gen.md
# block_coord_gen

Block-origin coordinate generator for the interpolation datapath. On START it walks a frame in raster order, block by block, and presents each block's upper-left signed 8-bit X/Y coordinate. For each block it issues a one-cycle write-enable pulse that loads the downstream coordinate registers. It then waits for the datapath to report completion before issuing the next block.

## Interface
Parameters:
- BLOCK_W, 8, block width in pixels (power of two)
- BLOCK_H, 8, block height in pixels (power of two)
- FRAME_W, 64, frame width in pixels; multiple of BLOCK_W, FRAME_W-BLOCK_W ≤ 127
- FRAME_H, 64, frame height in pixels; multiple of BLOCK_H, FRAME_H-BLOCK_H ≤ 127

Ports (one clock; reset is synchronous and active-high):
- CLK  input  1  clock, rising edge
- RST_SYNC  input  1  synchronous active-high reset
- START  input  1  begin frame scan; honoured only in IDLE
- READY_IN  input  1  datapath finished current block; sampled only in WAIT
- COORD_X  output  signed [7:0]  block origin X (registered)
- COORD_Y  output  signed [7:0]  block origin Y (registered)
- WRITE_EN  output  1  one-cycle pulse; COORD_X/COORD_Y valid and stable on this cycle
- BUSY  output  1  high in every state except IDLE
- DONE  output  1  one-cycle pulse after the last block is acknowledged

## Operation
- FSM states and transitions:
  - IDLE: START=1 → ISSUE, with origin (0,0).
  - ISSUE: WRITE_EN=1 for exactly one cycle → WAIT.
  - WAIT: hold until READY_IN=1. If the current block is the last one → FINISH. Otherwise advance the origin → ISSUE.
  - FINISH: DONE=1 for one cycle → IDLE.
- Origin advance, raster order:
  - If x_org+BLOCK_W < FRAME_W: x_org += BLOCK_W.
  - Otherwise: x_org = 0 and y_org += BLOCK_H.
  - The last block is x_org=FRAME_W-BLOCK_W, y_org=FRAME_H-BLOCK_H.
- Output mapping:
  - COORD_X = x_org − OFFSET, COORD_Y = y_org − OFFSET.
  - OFFSET is 0 or MARGIN (see Configuration).
  - Coordinates are 8-bit two's complement; they never wrap for legal parameters.
- Coordinates hold their value from ISSUE through WAIT and FINISH. They are not cleared in IDLE; they keep the last value until the next START.
- Total WRITE_EN pulses per frame = (FRAME_W/BLOCK_W)·(FRAME_H/BLOCK_H), i.e. 64 at defaults.
- Boundary conditions:
  - START while BUSY is ignored and does not restart the scan.
  - START and RST_SYNC on the same cycle: reset wins.
  - READY_IN high during ISSUE, FINISH or IDLE is ignored, never latched.
  - RST_SYNC mid-scan: next edge → IDLE, remaining blocks abandoned, no DONE pulse.
- Reset values: COORD_X=0, COORD_Y=0, WRITE_EN=0, BUSY=0, DONE=0, state IDLE, internal origin (0,0).

## Timing
- All outputs are registered; there are no combinational input→output paths.
- START sampled at edge n → WRITE_EN high in cycle n+1, with COORD = first origin.
- READY_IN sampled high in WAIT at edge m → next WRITE_EN in cycle m+1.
- Minimum block period is 2 cycles (ISSUE, WAIT with READY_IN already high).
- Last READY_IN at edge m → DONE in cycle m+1, BUSY low from cycle m+2.
- With READY_IN tied high, a default frame completes 129 cycles after the START edge (64 blocks × 2 cycles, plus FINISH).

## Configuration
- Macro BLOCK_COORD_GEN_MARGIN_EN.
- Defined: OFFSET = MARGIN = 3, so the origins include the left/top 8-tap filter border. The first block emits (−3,−3); the last default block emits (53,53).
- Undefined: OFFSET = 0. Emitted coordinates equal the block origins: (0,0) … (56,56).
- The FSM and handshake are identical in both builds.

## Structure
- Shared package coord_gen_pkg holds:
  - COORD_W = 8
  - MARGIN = 3
  - the FSM state typedef (IDLE, ISSUE, WAIT, FINISH)
- One sub-module, coord_axis_cnt, instantiated twice (X and Y). Each instance is a step counter with inputs clear, step, step size and limit. Its outputs are the origin and an at-last flag. The X instance's wrap drives the Y instance's step.

## Test plan
- Reset, then START, with READY_IN tied high, macro undefined → 64 WRITE_EN pulses. Coordinates go (0,0),(8,0)…(56,0),(0,8)…(56,56). DONE lands on cycle 129 after the START edge.
- Macro defined, same stimulus → first pulse (−3,−3) = 8'hFD/8'hFD, last pulse (53,53).
- READY_IN held low for 5 cycles in WAIT, and pulsed high during ISSUE → COORD stays stable, no extra WRITE_EN, the ISSUE-cycle READY_IN is ignored.
- START pulsed again on block 10 → scan continues unchanged, exactly 64 pulses in total.
- RST_SYNC asserted after block 20's WRITE_EN → next cycle all outputs are 0 and state is IDLE, no DONE. A new START restarts at (0,0).
- Parameters 16×8 block in a 32×16 frame → 4 pulses: (0,0),(16,0),(0,8),(16,8), then DONE.
